// File: rtl/rate_digit_counter.sv
// Multi-digit hex/BCD display counter stepped by a selectable-rate clock-enable divider.
// Each digit is a cell in a ripple carry/borrow chain that also drives its own 7-seg decoder.

module rate_digit_cell #(
  parameter bit BCD = 1'b0
) (
  input  logic [3:0] d_i,
  input  logic       ci_i,
  input  logic       up_i,
  output logic [3:0] nxt_o,
  output logic       co_o,
  output logic [6:0] seg_o
);
  localparam logic [3:0] MAX = BCD ? 4'd9 : 4'd15;

  // ci_i is the carry (up) or borrow (down) entering this digit.
  always_comb begin
    nxt_o = d_i;
    co_o  = 1'b0;
    if (ci_i) begin
      if (up_i) begin
        if (d_i == MAX) begin
          nxt_o = 4'd0;
          co_o  = 1'b1;
        end else begin
          nxt_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == 4'd0) begin
          nxt_o = MAX;
          co_o  = 1'b1;
        end else begin
          nxt_o = d_i - 4'd1;
        end
      end
    end
  end

  always_comb begin
    case (d_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end
endmodule

module rate_digit_counter #(
  parameter int DIGITS = 2,
  parameter bit BCD    = 1'b0,
  parameter int DIV0   = 1,
  parameter int DIV1   = 12500000,
  parameter int DIV2   = 25000000,
  parameter int DIV3   = 50000000,
  parameter int DIV_W  = 26
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [1:0]            sel_i,
  input  logic                  run_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_value_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  tick_o,
  output logic                  wrap_o,
  output logic [7*DIGITS-1:0]   hex_o
);
  localparam logic [DIV_W-1:0] LAST0 = DIV_W'(DIV0 - 1);
  localparam logic [DIV_W-1:0] LAST1 = DIV_W'(DIV1 - 1);
  localparam logic [DIV_W-1:0] LAST2 = DIV_W'(DIV2 - 1);
  localparam logic [DIV_W-1:0] LAST3 = DIV_W'(DIV3 - 1);

  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, cnt_step, ld_val;
  logic [DIGITS-1:0][6:0] seg;
  logic [DIGITS:0]        carry;
  logic [DIV_W-1:0]       div_q, div_d, div_last;
  logic [1:0]             sel_q;
  logic                   tick_q, tick_d, wrap_q, wrap_d;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    rate_digit_cell #(.BCD(BCD)) u_cell (
      .d_i   (cnt_q[g]),
      .ci_i  (carry[g]),
      .up_i  (up_i),
      .nxt_o (cnt_step[g]),
      .co_o  (carry[g+1]),
      .seg_o (seg[g])
    );
    // Decimal mode never admits a digit above 9, so the carry chain stays valid.
    assign ld_val[g] = (BCD && (load_value_i[4*g +: 4] > 4'd9)) ? 4'd0
                                                                 : load_value_i[4*g +: 4];
  end

  always_comb begin
    case (sel_q)
      2'd0:    div_last = LAST0;
      2'd1:    div_last = LAST1;
      2'd2:    div_last = LAST2;
      default: div_last = LAST3;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (load_i) begin
      cnt_d = ld_val;
      div_d = '0;
    end else if (sel_i != sel_q) begin
      div_d = '0;
    end else if (run_i) begin
      if (div_q == div_last) begin
        div_d  = '0;
        cnt_d  = cnt_step;
        tick_d = 1'b1;
        wrap_d = carry[DIGITS];
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q  <= '0;
      div_q  <= '0;
      sel_q  <= sel_i;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sel_q  <= sel_i;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign count_o = cnt_q;
  assign hex_o   = seg;
  assign tick_o  = tick_q;
  assign wrap_o  = wrap_q;
endmodule

// File: tb/tb_rate_digit_counter.sv
// Bench for rate_digit_counter: a hex and a BCD instance share stimulus and are
// compared every cycle against an integer-arithmetic reference model.

module tb_rate_digit_counter;
  localparam int D    = 2;
  localparam int HMOD = 256;
  localparam int BMOD = 100;
  int DIVS [4] = '{1, 4, 3, 7};

  logic clock = 1'b0;
  logic resetn;
  logic [1:0] sel;
  logic run, up, load;
  logic [4*D-1:0] lv;
  logic [4*D-1:0] cnt_h, cnt_b;
  logic tick_h, tick_b, wrap_h, wrap_b;
  logic [7*D-1:0] hex_h, hex_b;

  int checks = 0;
  int failures = 0;

  logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // reference state: plain integer values, phase within the step period
  int m_h, m_b, m_div, m_sel;
  bit m_tick, m_wrap_h, m_wrap_b;

  always #5 clock = ~clock;

  rate_digit_counter #(.DIGITS(D), .BCD(1'b0), .DIV0(1), .DIV1(4), .DIV2(3), .DIV3(7), .DIV_W(4)) u_hex (
    .clock(clock), .resetn(resetn), .sel_i(sel), .run_i(run), .up_i(up), .load_i(load),
    .load_value_i(lv), .count_o(cnt_h), .tick_o(tick_h), .wrap_o(wrap_h), .hex_o(hex_h));

  rate_digit_counter #(.DIGITS(D), .BCD(1'b1), .DIV0(1), .DIV1(4), .DIV2(3), .DIV3(7), .DIV_W(4)) u_bcd (
    .clock(clock), .resetn(resetn), .sel_i(sel), .run_i(run), .up_i(up), .load_i(load),
    .load_value_i(lv), .count_o(cnt_b), .tick_o(tick_b), .wrap_o(wrap_b), .hex_o(hex_b));

  function automatic logic [4*D-1:0] to_bcd(int n);
    logic [4*D-1:0] r;
    int v = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] segs(logic [4*D-1:0] c);
    logic [7*D-1:0] r;
    for (int i = 0; i < D; i++) r[7*i +: 7] = SEG[c[4*i +: 4]];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    if (!resetn) begin
      m_h = 0; m_b = 0; m_div = 0; m_sel = int'(sel);
      m_tick = 0; m_wrap_h = 0; m_wrap_b = 0;
      return;
    end
    m_tick = 0; m_wrap_h = 0; m_wrap_b = 0;
    if (load) begin
      int dec = 0, w = 1;
      m_h = int'(lv);
      for (int i = 0; i < D; i++) begin
        int dg = int'(lv[4*i +: 4]);
        dec += ((dg > 9) ? 0 : dg) * w;
        w *= 10;
      end
      m_b = dec;
      m_div = 0;
    end else if (int'(sel) != m_sel) begin
      m_div = 0;
    end else if (run) begin
      if (m_div == DIVS[m_sel] - 1) begin
        m_div = 0;
        m_tick = 1;
        if (up) begin
          m_wrap_h = (m_h == HMOD - 1); m_wrap_b = (m_b == BMOD - 1);
          m_h = (m_h + 1) % HMOD;       m_b = (m_b + 1) % BMOD;
        end else begin
          m_wrap_h = (m_h == 0); m_wrap_b = (m_b == 0);
          m_h = (m_h + HMOD - 1) % HMOD; m_b = (m_b + BMOD - 1) % BMOD;
        end
      end else begin
        m_div++;
      end
    end
    m_sel = int'(sel);
  endtask

  task automatic cyc();
    @(posedge clock);
    model();
    #1;
    chk("count_hex", cnt_h, m_h);
    chk("tick_hex",  tick_h, m_tick);
    chk("wrap_hex",  wrap_h, m_wrap_h);
    chk("seg_hex",   hex_h, segs(m_h[4*D-1:0]));
    chk("count_bcd", cnt_b, to_bcd(m_b));
    chk("tick_bcd",  tick_b, m_tick);
    chk("wrap_bcd",  wrap_b, m_wrap_b);
    chk("seg_bcd",   hex_b, segs(to_bcd(m_b)));
  endtask

  initial begin
    resetn = 0; sel = 2'd1; run = 1; up = 1; load = 0; lv = '0;
    m_h = 0; m_b = 0; m_div = 0; m_sel = 1; m_tick = 0; m_wrap_h = 0; m_wrap_b = 0;

    // reset
    cyc(); cyc();
    chk("rst_count", cnt_h, 0);
    chk("rst_tick", tick_h, 0);
    chk("rst_hex", hex_h, {7'b1000000, 7'b1000000});

    // rate: sel=1 -> step every 4th clock
    resetn = 1;
    repeat (3) cyc();
    chk("rate_no_tick_early", tick_h, 0);
    cyc();
    chk("rate_first_step", cnt_h, 8'h01);
    chk("rate_first_tick", tick_h, 1);
    repeat (4) cyc();
    chk("rate_second_step", cnt_h, 8'h02);
    repeat (2) cyc();
    sel = 2'd0; cyc();
    chk("selchg_no_step", tick_h, 0);
    cyc();
    chk("sel0_step", tick_h, 1);
    chk("sel0_count", cnt_h, 8'h03);

    // hex wrap up and down
    load = 1; lv = 8'hFE; cyc(); load = 0;
    cyc(); chk("hex_ff", cnt_h, 8'hFF); chk("hex_ff_nowrap", wrap_h, 0);
    cyc(); chk("hex_00", cnt_h, 8'h00); chk("hex_wrap_up", wrap_h, 1);
    up = 0; cyc(); chk("hex_down_ff", cnt_h, 8'hFF); chk("hex_wrap_dn", wrap_h, 1);

    // BCD carry, wrap, load clamp, borrow wrap
    up = 1; load = 1; lv = 8'h98; cyc(); load = 0;
    cyc(); chk("bcd_99", cnt_b, 8'h99);
    cyc(); chk("bcd_00", cnt_b, 8'h00); chk("bcd_wrap", wrap_b, 1);
    cyc(); chk("bcd_01", cnt_b, 8'h01); chk("bcd_nowrap", wrap_b, 0);
    load = 1; lv = 8'hA5; cyc(); chk("bcd_clamp", cnt_b, 8'h05);
    lv = 8'h00; cyc(); load = 0; up = 0;
    cyc(); chk("bcd_dn_99", cnt_b, 8'h99); chk("bcd_dn_wrap", wrap_b, 1);

    // pause mid-period, then load on the terminal divider cycle
    up = 1; sel = 2'd1; cyc(); cyc();
    run = 0; repeat (10) cyc();
    chk("pause_tick", tick_h, 0);
    run = 1;
    for (int i = 0; i < 8 && m_div != DIVS[1] - 1; i++) cyc();
    chk("reach_terminal", m_div, DIVS[1] - 1);
    load = 1; lv = 8'h42; cyc(); load = 0;
    chk("load42", cnt_h, 8'h42); chk("load_no_tick", tick_h, 0);
    repeat (3) cyc();
    chk("post_load_wait", tick_h, 0);
    cyc();
    chk("post_load_step", tick_h, 1); chk("post_load_cnt", cnt_h, 8'h43);

    // segment sweep
    run = 0; sel = 2'd0;
    for (int v = 0; v < 16; v++) begin
      load = 1; lv = 8'(v); cyc();
      chk("seg_sweep", hex_h[6:0], SEG[v]);
    end
    load = 0;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      run  = ($urandom_range(0, 9) != 0);
      up   = 1'($urandom);
      load = ($urandom_range(0, 29) == 0);
      lv   = 8'($urandom);
      if ($urandom_range(0, 39) == 0) sel = 2'($urandom);
      resetn = ($urandom_range(0, 149) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
